fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Drives the program counter register's update interface: reads its current value
//  (pc_out) and produces its next value (pc_in, pc_WEN). Issues instruction reads to the
//  I-side cache and holds each fetched word in a one-entry buffer for decode
//  (valid/ready). Handles control-flow redirects from execute and stops fetching on HALT.
// PARAMETERS
//  PC_STEP   4       byte increment applied to PC after each accepted fetch
//  HALT_OP   6'h3F   opcode (iload[31:26]) that marks a HALT instruction
// PORTS
//  clk          in   1   system clock, all state on posedge
//  nRst         in   1   asynchronous active-low reset
//  pc_out       in   32  current PC from program counter register
//  pc_in        out  32  next PC value for program counter register
//  pc_WEN       out  1   program counter write enable
//  iREN         out  1   instruction read request to cache
//  iaddr        out  32  instruction read address
//  ihit         in   1   cache returns iload this cycle (same-cycle hit)
//  iload        in   32  instruction word from cache
//  instr        out  32  buffered instruction to decode
//  instr_pc     out  32  PC of buffered instruction
//  instr_valid  out  1   buffer holds a valid instruction
//  instr_ready  in   1   decode accepts instr this cycle
//  redirect     in   1   branch/jump taken, flush and refetch
//  redirect_pc  in   32  target of redirect
//  halted       out  1   HALT has been accepted by decode; core stopped
//  fetch_count  out  32  number of instructions delivered to decode (perf)
// BEHAVIOUR
//  Reset (nRst low, async): state=RUN, instr=0, instr_pc=0, instr_valid=0, halted=0,
//   fetch_count=0; combinational outputs iREN=0, pc_WEN=0, pc_in=0, iaddr=0 while low.
//  States: RUN (fetching), DRAIN (HALT buffered, awaiting accept), HALTED (terminal).
//  accept = instr_valid & instr_ready; space = !instr_valid | accept.
//  iaddr = pc_out always (outside reset).
//  Priority per cycle: reset > redirect > fetch.
//  RUN, redirect=1: iREN=0, pc_WEN=1, pc_in=redirect_pc; instr_valid<=0 next edge;
//   any ihit/iload this cycle discarded; fetch_count unchanged even if accept=1.
//  RUN, no redirect: iREN=space. If iREN & ihit: instr<=iload, instr_pc<=pc_out,
//   instr_valid<=1. If fetched word is not HALT, pc_WEN=1 and pc_in=pc_out+PC_STEP
//   (32-bit modulo, 0xFFFFFFFC wraps to 0x0). If it is HALT (iload[31:26]==HALT_OP):
//   pc_WEN=0, state<=DRAIN. Else if accept only: instr_valid<=0.
//  Latency: fetch in cycle N -> instr_valid=1 from cycle N+1; one instr/cycle at full
//   throughput (accept and new capture in same cycle replace the entry).
//  Backpressure: instr_valid=1 & instr_ready=0 -> iREN=0, pc_WEN=0, instr/instr_pc
//   held stable.
//  DRAIN: iREN=0, pc_WEN=0. redirect=1 -> flush buffer, pc_WEN=1, pc_in=redirect_pc,
//   state<=RUN (HALT was on wrong path). Else on accept: instr_valid<=0, halted<=1,
//   state<=HALTED.
//  HALTED: iREN=0, pc_WEN=0, halted=1; redirect ignored; only reset exits.
//  fetch_count increments by 1 on every accept with no same-cycle redirect;
//   wraps modulo 2^32.
//  ihit while iREN=0 is ignored.
// TESTING
//  T1 reset, pc_out=0, ihit=1, iload=0x20010005, ready=1 -> cycle0 iREN=1 iaddr=0 pc_WEN=1
//     pc_in=4; cycle1 instr_valid=1 instr=0x20010005 instr_pc=0; count=1 after accept.
//  T2 buffer full, instr_ready=0 for 3 cycles -> iREN=0, pc_WEN=0, instr unchanged;
//     ready=1 -> accept, fetch resumes at next PC same cycle.
//  T3 redirect=1, redirect_pc=0x100 with ihit=1 -> pc_in=0x100 pc_WEN=1, instr_valid=0
//     next cycle, fetch_count unchanged.
//  T4 iload=0xFFFFFFFF at pc 0x8 -> pc_WEN=0, DRAIN; after accept halted=1, iREN=0
//     forever; later redirect leaves pc_WEN=0.
//  T5 redirect to 0x40 while in DRAIN -> buffer flushed, halted stays 0, fetch at 0x40.
//  T6 nRst low mid-stall with instr_valid=1 -> all outputs 0 immediately; restart at T1.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, I-cache fetch into a one-entry decode buffer, redirect and HALT handling
module fetch_unit #(
  parameter logic [31:0] PC_STEP = 32'd4,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [31:0] pc_out,
  output logic [31:0] pc_in,
  output logic        pc_WEN,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_n;
  logic accept, space, is_halt, redir, fetch;
  assign accept  = instr_valid & instr_ready;
  assign space   = !instr_valid | accept;
  assign is_halt = iload[31:26] == HALT_OP;
  assign redir   = redirect & (state != HALTED);
  assign fetch   = iREN & ihit;
  assign halted  = state == HALTED;
  // All combinational outputs are forced low while reset is held.
  always_comb begin
    state_n = state;
    iREN    = 1'b0;
    pc_WEN  = 1'b0;
    pc_in   = '0;
    iaddr   = '0;
    if (nRst) begin
      iaddr   = pc_out;
      iREN    = state == RUN && !redirect && space;
      pc_WEN  = redir | (iREN & ihit & !is_halt);
      pc_in   = redir ? redirect_pc : pc_out + PC_STEP;
      state_n = redir ? RUN :
                (state == RUN && iREN && ihit && is_halt) ? DRAIN :
                (state == DRAIN && accept) ? HALTED : state;
    end
  end
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) state <= RUN;
    else state <= state_n;
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (accept && !redirect) fetch_count <= fetch_count + 32'd1;
      if (fetch) begin
        instr       <= iload;
        instr_pc    <= pc_out;
        instr_valid <= 1'b1;
      end else if (redir || accept) instr_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with a PC register model and a fetch scoreboard
module tb_fetch_unit;
  logic        clk = 1'b0, nRst = 1'b0;
  logic [31:0] pc_out, pc_in, iaddr, iload = '0, instr, instr_pc, redirect_pc = '0, fetch_count;
  logic        pc_WEN, iREN, ihit = 1'b0, instr_valid, instr_ready = 1'b0, redirect = 1'b0, halted;
  int          checks = 0, errors = 0;
  logic [63:0] sb[$];

  fetch_unit dut (
    .clk(clk), .nRst(nRst), .pc_out(pc_out), .pc_in(pc_in), .pc_WEN(pc_WEN),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge nRst)
    if (!nRst) pc_out <= '0;
    else if (pc_WEN) pc_out <= pc_in;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic ih, logic [31:0] ld, logic rdy, logic rd, logic [31:0] rpc);
    @(negedge clk);
    ihit = ih; iload = ld; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
  endtask

  task automatic pop_chk(string tag);
    logic [63:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
      chk({tag, "_instr"}, instr, e[63:32]);
      chk({tag, "_pc"}, instr_pc, e[31:0]);
    end
  endtask

  initial begin
    #3;
    chk("rst_iren", {31'b0, iREN}, 0);
    chk("rst_wen", {31'b0, pc_WEN}, 0);
    chk("rst_pcin", pc_in, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    @(negedge clk) nRst = 1'b1;
    // T1: first fetch and delivery
    drive(1, 32'h20010005, 1, 0, 0);
    chk("t1_iren", {31'b0, iREN}, 1);
    chk("t1_iaddr", iaddr, 0);
    chk("t1_wen", {31'b0, pc_WEN}, 1);
    chk("t1_pcin", pc_in, 4);
    sb.push_back({32'h20010005, 32'h0});
    drive(0, 0, 1, 0, 0);
    pop_chk("t1_deliver");
    chk("t1_count0", fetch_count, 0);
    // T2: backpressure then release
    drive(1, 32'h11111111, 0, 0, 0);
    chk("t2_count1", fetch_count, 1);
    chk("t2_iren", {31'b0, iREN}, 1);
    chk("t2_pcin", pc_in, 8);
    sb.push_back({32'h11111111, 32'h4});
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h22222222, 0, 0, 0);
      chk("t2_stall_iren", {31'b0, iREN}, 0);
      chk("t2_stall_wen", {31'b0, pc_WEN}, 0);
      chk("t2_stall_instr", instr, 32'h11111111);
      chk("t2_stall_pc", instr_pc, 4);
    end
    drive(1, 32'h22222222, 1, 0, 0);
    chk("t2_resume_iren", {31'b0, iREN}, 1);
    chk("t2_resume_iaddr", iaddr, 8);
    chk("t2_resume_pcin", pc_in, 32'hC);
    pop_chk("t2_deliver");
    sb.push_back({32'h22222222, 32'h8});
    // T3: redirect with a concurrent hit and accept
    drive(1, 32'h33333333, 1, 1, 32'h100);
    chk("t3_iren", {31'b0, iREN}, 0);
    chk("t3_wen", {31'b0, pc_WEN}, 1);
    chk("t3_pcin", pc_in, 32'h100);
    pop_chk("t3_flushed");
    drive(0, 0, 1, 0, 0);
    chk("t3_valid", {31'b0, instr_valid}, 0);
    chk("t3_count", fetch_count, 2);
    chk("t3_iaddr", iaddr, 32'h100);
    // T4: HALT at 0x8
    drive(0, 0, 1, 1, 32'h8);
    chk("t4_redir_pcin", pc_in, 8);
    drive(1, 32'hFFFFFFFF, 0, 0, 0);
    chk("t4_iren", {31'b0, iREN}, 1);
    chk("t4_wen", {31'b0, pc_WEN}, 0);
    sb.push_back({32'hFFFFFFFF, 32'h8});
    drive(1, 32'hFFFFFFFF, 0, 0, 0);
    chk("t4_drain_iren", {31'b0, iREN}, 0);
    chk("t4_drain_halted", {31'b0, halted}, 0);
    drive(0, 0, 1, 0, 0);
    pop_chk("t4_deliver");
    chk("t4_accept_iren", {31'b0, iREN}, 0);
    drive(1, 32'h12345678, 1, 1, 32'h40);
    chk("t4_halted", {31'b0, halted}, 1);
    chk("t4_redir_wen", {31'b0, pc_WEN}, 0);
    chk("t4_halt_iren", {31'b0, iREN}, 0);
    chk("t4_count", fetch_count, 3);
    drive(0, 0, 1, 0, 0);
    chk("t4_still_halted", {31'b0, halted}, 1);
    chk("t4_iaddr", iaddr, 8);
    @(negedge clk) nRst = 1'b0;
    #1 chk("t4_rst_halted", {31'b0, halted}, 0);
    @(negedge clk) nRst = 1'b1;
    // T5: redirect out of DRAIN
    drive(1, 32'hFC000000, 0, 0, 0);
    chk("t5_wen", {31'b0, pc_WEN}, 0);
    sb.push_back({32'hFC000000, 32'h0});
    drive(0, 0, 1, 1, 32'h40);
    chk("t5_iren", {31'b0, iREN}, 0);
    chk("t5_pcin", pc_in, 32'h40);
    chk("t5_wen2", {31'b0, pc_WEN}, 1);
    pop_chk("t5_flushed");
    drive(1, 32'h44444444, 0, 0, 0);
    chk("t5_halted", {31'b0, halted}, 0);
    chk("t5_valid", {31'b0, instr_valid}, 0);
    chk("t5_count", fetch_count, 0);
    chk("t5_iaddr", iaddr, 32'h40);
    chk("t5_iren2", {31'b0, iREN}, 1);
    chk("t5_pcin2", pc_in, 32'h44);
    sb.push_back({32'h44444444, 32'h40});
    drive(0, 0, 0, 0, 0);
    chk("t6_pre_valid", {31'b0, instr_valid}, 1);
    // T6: asynchronous reset mid-stall
    #2 nRst = 1'b0;
    #1;
    chk("t6_valid", {31'b0, instr_valid}, 0);
    chk("t6_instr", instr, 0);
    chk("t6_pc", instr_pc, 0);
    chk("t6_iren", {31'b0, iREN}, 0);
    chk("t6_wen", {31'b0, pc_WEN}, 0);
    chk("t6_pcin", pc_in, 0);
    chk("t6_iaddr", iaddr, 0);
    sb.delete();
    @(negedge clk) nRst = 1'b1;
    drive(1, 32'h20010005, 1, 0, 0);
    chk("t6_restart_iaddr", iaddr, 0);
    chk("t6_restart_pcin", pc_in, 4);
    sb.push_back({32'h20010005, 32'h0});
    // redirect coinciding with accept, then PC wrap at the top of memory
    drive(0, 0, 1, 1, 32'hFFFFFFFC);
    pop_chk("wrap_redir_accept");
    drive(1, 32'hABCD0000, 1, 0, 0);
    chk("wrap_count", fetch_count, 0);
    chk("wrap_iaddr", iaddr, 32'hFFFFFFFC);
    chk("wrap_wen", {31'b0, pc_WEN}, 1);
    chk("wrap_pcin", pc_in, 0);
    sb.push_back({32'hABCD0000, 32'hFFFFFFFC});
    drive(0, 0, 1, 0, 0);
    pop_chk("wrap_deliver");
    chk("wrap_pc_reg", pc_out, 0);
    drive(0, 0, 0, 0, 0);
    chk("wrap_count1", fetch_count, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
